sram_arb_2p: RTL and testbench
==============================

SRAM_ARB_2P -- requirements
Module: sram_arb_2p

Interface
- REQ-001: DATA_WIDTH, 8, data width of the SRAM macro word and the requester data buses.
- REQ-002: ADDR_WIDTH, 8, SRAM address width; 256 words at default.
- REQ-003: clk0  input  1  single clock; the SRAM macro shares this clock.
- REQ-004: rst0  input  1  asynchronous, active-high reset.
- REQ-005: rN_valid (N=0,1)  input  1  request valid from requester N.
- REQ-006: rN_ready  output  1  request accepted this cycle when high with rN_valid.
- REQ-007: rN_we  input  1  1 = write, 0 = read.
- REQ-008: rN_addr  input  ADDR_WIDTH  word address.
- REQ-009: rN_wdata  input  DATA_WIDTH  write data.
- REQ-010: rN_rvalid  output  1  one-cycle pulse; rN_rdata is valid.
- REQ-011: rN_rdata  output  DATA_WIDTH  read data returned to requester N.
- REQ-012: rN_wdone  output  1  one-cycle pulse; requester N's write has been issued to the macro.
- REQ-013: sram_csb0, sram_web0  output  1 each  active-low chip select and write enable to the macro.
- REQ-014: sram_addr0 (ADDR_WIDTH), sram_din0 (DATA_WIDTH)  output  macro address and write data.
- REQ-015: sram_dout0  input  DATA_WIDTH  macro read data.
- REQ-016: busy  output  1  high in any state other than IDLE.

Function
- REQ-017: FSM states are IDLE, ISSUE, WAIT and RESP; all SRAM-side outputs are registered.
- REQ-018: In IDLE, exactly one rN_ready SHALL be high, for the grant winner, and only if that requester has rN_valid high. In every other state both rN_ready are low.
- REQ-019: Accept is rN_valid && rN_ready. On the accept edge, the block drives sram_csb0=0, sram_web0=!rN_we, sram_addr0=rN_addr and sram_din0=rN_wdata; it records the owner N and the transaction type, and moves IDLE->ISSUE.
- REQ-020: ISSUE lasts one cycle, during which the macro samples its inputs. At the ISSUE exit edge, sram_csb0 returns to 1 and sram_web0 returns to 1.
  - Write: ISSUE->RESP.
  - Read: ISSUE->WAIT.
- REQ-021: In WAIT, at the exit edge, the block registers sram_dout0 into rN_rdata of the owner and moves WAIT->RESP.
- REQ-022: RESP lasts one cycle and then returns to IDLE.
  - Read: the owner's rN_rvalid pulses for exactly that cycle.
  - Write: the owner's rN_wdone pulses for exactly that cycle.
- REQ-023: Latency from accept edge to response pulse is fixed: 3 cycles for a read, 2 cycles for a write. Back-to-back accepts are separated by at least 4 cycles (read) or 3 cycles (write).
- REQ-024: Round-robin arbitration uses a 1-bit last-served pointer.
  - If both requesters are valid, the one not last served wins.
  - If only one is valid, it wins.
  - The pointer updates only on accept.
- REQ-025: The block performs no address or data arithmetic; addresses and data pass unmodified. The full address range 0..2^ADDR_WIDTH-1 is legal.
- REQ-026: A requester SHALL hold rN_valid, rN_we, rN_addr and rN_wdata stable until accept; the block does not check this.
- REQ-027: rN_rdata of a non-owner holds its previous value.
- REQ-028: Accesses are serviced strictly in accept order, so a read after a write to the same address returns the written data.

Reset
- REQ-029: While rst0 is high, all of the following hold immediately and asynchronously:
  - state=IDLE and the pointer selects port 0 first (last-served=1);
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0;
  - all rN_ready, rN_rvalid and rN_wdone are 0, rN_rdata=0 and busy=0.
- REQ-030: Reset asserted mid-transaction aborts it with no response pulse. A write already sampled by the macro may complete; this is permitted.

Configuration
- REQ-031: Macro SRAM_ARB_FIXED_PRIO_EN selects the arbitration scheme.
  - Defined: requester 0 always wins when both are valid; the pointer is not implemented.
  - Undefined: round-robin per REQ-024.

Structure
- REQ-032: Shared package sram_arb_pkg holds the state enum, the DATA_WIDTH/ADDR_WIDTH defaults and the owner-ID type.
- REQ-033: Grant logic is one sub-module, sram_arb_grant: a 2-way round-robin or fixed-priority arbiter with pointer state.

Verification
- REQ-034: Write then read: r0 writes 0xA5 to addr 0x10, then r0 reads 0x10.
  - Required: r0_wdone 2 cycles after the write accept; r0_rvalid with r0_rdata=0xA5 3 cycles after the read accept.
- REQ-035: Simultaneous requests: r0 and r1 both valid after reset. Required grant order r0, r1, r0, r1. With SRAM_ARB_FIXED_PRIO_EN defined and r0 continuously valid, r1 is never granted.
- REQ-036: Address boundaries: write 0x3C to addr 0xFF and 0xC3 to addr 0x00, then read both. Required: 0x3C and 0xC3 are returned and no other word is disturbed.
- REQ-037: Cross-requester ordering: r1 writes 0x5A to addr 0x20, then r0 reads 0x20. Required: r0_rdata=0x5A.
- REQ-038: Reset in WAIT: assert rst0 during a read. Required: no r0_rvalid, all outputs at reset values, and the next request is granted normally.
- REQ-039: Hold check: r1 is valid while a transaction is busy. Required: r1_ready=0 until IDLE, then r1 is accepted in its first IDLE cycle.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared state encoding, width defaults and owner type for the two-port SRAM arbiter.
package sram_arb_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  typedef logic owner_t;
endpackage

// File: rtl/sram_arb_grant.sv
// Two-way arbiter: round-robin on a last-served bit, or fixed priority to port 0 when
// SRAM_ARB_FIXED_PRIO_EN is defined. Grant is combinational; the pointer moves only on accept.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic accept_i,
  output logic gnt_o
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic unused_w;
  assign unused_w = clk_i ^ rst_i ^ accept_i ^ req1_i;
  // Port 1 is only chosen when port 0 is idle; with no request the grant is don't-care.
  assign gnt_o = ~req0_i;
`else
  owner_t last_q, last_d;

  always_comb begin
    gnt_o = 1'b0;
    if (req0_i && req1_i) begin
      gnt_o = ~last_q;
    end else if (req1_i) begin
      gnt_o = 1'b1;
    end
    last_d = accept_i ? gnt_o : last_q;
  end

  // Reset to "port 1 last served" so port 0 wins the first contention.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: rtl/sram_arb_2p.sv
// Two requesters onto one single-port SRAM macro, one transaction in flight at a time.
// Response pulse 3 cycles after accept (read) or 2 (write); both readies stay low while busy.
module sram_arb_2p
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_wdone,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_wdone,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  busy
);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  rd_q, rd_d;
  logic                  csb_q, csb_d, web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  owner_t                gnt;
  logic                  idle, accept, resp, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  sram_arb_grant u_grant (
    .clk_i    (clk0),
    .rst_i    (rst0),
    .req0_i   (r0_valid),
    .req1_i   (r1_valid),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign idle = (state_q == ST_IDLE);
  assign resp = (state_q == ST_RESP);
  // Gating with rst0 drops ready the instant reset asserts rather than after an edge.
  assign r0_ready = ~rst0 & idle & r0_valid & ~gnt;
  assign r1_ready = ~rst0 & idle & r1_valid & gnt;
  assign accept   = r0_ready | r1_ready;

  assign sel_we    = gnt ? r1_we    : r0_we;
  assign sel_addr  = gnt ? r1_addr  : r0_addr;
  assign sel_wdata = gnt ? r1_wdata : r0_wdata;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rd_d     = rd_q;
    csb_d    = csb_q;
    web_d    = web_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          csb_d   = 1'b0;
          web_d   = ~sel_we;
          addr_d  = sel_addr;
          din_d   = sel_wdata;
          owner_d = gnt;
          rd_d    = ~sel_we;
        end
      end
      ST_ISSUE: begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        state_d = rd_q ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        state_d = ST_RESP;
        if (owner_q) begin
          rdata1_d = sram_dout0;
        end else begin
          rdata0_d = sram_dout0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      rd_q     <= 1'b0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rd_q     <= rd_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign sram_csb0  = csb_q;
  assign sram_web0  = web_q;
  assign sram_addr0 = addr_q;
  assign sram_din0  = din_q;
  assign r0_rdata   = rdata0_q;
  assign r1_rdata   = rdata1_q;
  assign r0_rvalid  = resp &  rd_q & ~owner_q;
  assign r0_wdone   = resp & ~rd_q & ~owner_q;
  assign r1_rvalid  = resp &  rd_q &  owner_q;
  assign r1_wdone   = resp & ~rd_q &  owner_q;
  assign busy       = ~idle;

endmodule

// File: tb/tb_sram_arb_2p.sv
// Self-checking bench for sram_arb_2p: SRAM macro model plus a transaction-level reference.
module tb_sram_arb_2p;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b0;
  logic          r0_valid, r0_ready, r0_we, r0_rvalid, r0_wdone;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_ready, r1_we, r1_rvalid, r1_wdone;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          sram_csb0, sram_web0, busy;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0 = '0;

  always #5 clk0 = ~clk0;

  sram_arb_2p dut (
    .clk0(clk0), .rst0(rst0),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_wdone(r0_wdone),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_wdone(r1_wdone),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0), .busy(busy)
  );

  // Synchronous single-port macro: inputs sampled on the clock edge, read data after it.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] = sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  int            n_total = 0;
  int            n_pass  = 0;
  logic          last_srv;
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_rd  [0:1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
    end
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? r0_ready : r1_ready;
  endfunction

  task automatic wait_ready(input int p, input string tag);
    int cyc = 0;
    #1;
    while (!ready_of(p) && cyc < 20) begin
      @(negedge clk0); #1; cyc++;
    end
    check(tag, ready_of(p), 1);
  endtask

  task automatic accept_model(input int p, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
    last_srv = p[0];
    if (we) ref_mem[a] = d;
  endtask

  // Called just after the accept edge; returns at the negedge of the first idle cycle.
  task automatic complete(input int p, input logic we, input logic [AW-1:0] a);
    int last_k = we ? 3 : 4;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk0);
      check("rvalid", (p == 0) ? r0_rvalid : r1_rvalid, 32'(!we && k == 3));
      check("wdone",  (p == 0) ? r0_wdone  : r1_wdone,  32'(we && k == 2));
      check("other_pulse", (p == 0) ? {r1_rvalid, r1_wdone} : {r0_rvalid, r0_wdone}, 0);
      check("busy", busy, 32'(k < last_k));
      if (k < last_k) check("ready_hold", {r0_ready, r1_ready}, 0);
      if (!we && k == 3) begin
        exp_rd[p] = ref_mem[a];
        check("rdata", (p == 0) ? r0_rdata : r1_rdata, exp_rd[p]);
      end
    end
    check("other_rdata", (p == 0) ? r1_rdata : r0_rdata, exp_rd[1-p]);
  endtask

  task automatic txn(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk0);
    set_req(p, 1'b1, we, a, d);
    wait_ready(p, "ready");
    @(posedge clk0);
    accept_model(p, we, a, d);
    #1 set_req(p, 1'b0, we, a, d);
    complete(p, we, a);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sram"}, {sram_csb0, sram_web0, sram_addr0, sram_din0}, {2'b11, 16'h0000});
    check({tag, "_ready"}, {r0_ready, r1_ready}, 0);
    check({tag, "_pulses"}, {r0_rvalid, r0_wdone, r1_rvalid, r1_wdone}, 0);
    check({tag, "_rdata"}, {r0_rdata, r1_rdata}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int            cyc;
    int            win;
    int            bad;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    int            p;

    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_srv  = 1'b1;

    // Reset values, with both requesters asserting valid to show ready stays gated.
    #1 rst0 = 1'b1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    #1 check_reset("rst");
    @(negedge clk0);
    @(negedge clk0);
    rst0 = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;

    // Contention straight after reset: alternating grants (or always r0 with fixed priority).
    @(negedge clk0);
    set_req(0, 1'b1, 1'b0, 8'h40, '0);
    set_req(1, 1'b1, 1'b0, 8'h41, '0);
    for (int g = 0; g < 4; g++) begin
      cyc = 0;
      #1;
      while (!(r0_ready || r1_ready) && cyc < 20) begin
        @(negedge clk0); #1; cyc++;
      end
`ifdef SRAM_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win = last_srv ? 0 : 1;
`endif
      check("grant", {r0_ready, r1_ready}, (win == 0) ? 2'b10 : 2'b01);
      @(posedge clk0);
      a = 8'h40 + 8'(win);
      accept_model(win, 1'b0, a, '0);
      complete(win, 1'b0, a);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);

    // Write then read on r0.
    txn(0, 1'b1, 8'h10, 8'hA5);
    txn(0, 1'b0, 8'h10, 8'h00);
    check("wr_rd_a5", r0_rdata, 8'hA5);

    // Cross-requester ordering.
    txn(1, 1'b1, 8'h20, 8'h5A);
    txn(0, 1'b0, 8'h20, 8'h00);
    check("cross_5a", r0_rdata, 8'h5A);

    // Address boundaries and their neighbours.
    txn(0, 1'b1, 8'hFF, 8'h3C);
    txn(1, 1'b1, 8'h00, 8'hC3);
    txn(0, 1'b0, 8'hFF, 8'h00);
    check("bound_ff", r0_rdata, 8'h3C);
    txn(1, 1'b0, 8'h00, 8'h00);
    check("bound_00", r1_rdata, 8'hC3);
    txn(0, 1'b0, 8'hFE, 8'h00);
    txn(1, 1'b0, 8'h01, 8'h00);

    // r1 waits while r0 is in flight and is accepted in the first idle cycle.
    @(negedge clk0);
    set_req(0, 1'b1, 1'b0, 8'h55, '0);
    wait_ready(0, "hold_r0_ready");
    @(posedge clk0);
    accept_model(0, 1'b0, 8'h55, '0);
    #1 set_req(0, 1'b0, 1'b0, 8'h55, '0);
    set_req(1, 1'b1, 1'b1, 8'h56, 8'h99);
    complete(0, 1'b0, 8'h55);
    #1 check("hold_first_idle", r1_ready, 1);
    @(posedge clk0);
    accept_model(1, 1'b1, 8'h56, 8'h99);
    #1 set_req(1, 1'b0, 1'b1, 8'h56, 8'h99);
    complete(1, 1'b1, 8'h56);

    // Reset while a read sits in WAIT: aborted, no pulse, then normal service.
    @(negedge clk0);
    set_req(0, 1'b1, 1'b0, 8'h10, '0);
    wait_ready(0, "rstw_ready");
    @(posedge clk0);
    #1 set_req(0, 1'b0, 1'b0, 8'h10, '0);
    @(negedge clk0);
    check("rstw_issue_busy", busy, 1);
    @(negedge clk0);
    rst0 = 1'b1;
    #1 check_reset("rstw");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk0);
      check("rstw_no_rvalid", {r0_rvalid, r1_rvalid}, 0);
    end
    rst0      = 1'b0;
    last_srv  = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    txn(1, 1'b0, 8'h10, 8'h00);
    check("rstw_after", r1_rdata, 8'hA5);

    // Randomized single-requester traffic on a small address window.
    for (int t = 0; t < 40; t++) begin
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 31));
      d  = 8'($urandom);
      txn(p, we, a, d);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) bad++;
    end
    check("mem_sweep", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
